// File: rtl/gpio_pkg.sv
// Shared constants for the parallel I/O port: default sizing and DIR bit encoding.
package gpio_pkg;

    localparam int GPIO_WIDTH     = 8;
    localparam int GPIO_DB_CYCLES = 4;

    localparam logic DIR_IN  = 1'b0;
    localparam logic DIR_OUT = 1'b1;

    function automatic logic is_input(input logic dir);
        return dir == DIR_IN;
    endfunction

endpackage

// File: rtl/gpio_in_bit.sv
// One port bit's input path: 2-flop synchronizer, optional debounce (GPIO_DEBOUNCE_EN), edge detect.
// stb lags the pad by 2 edges (plus DB_CYCLES with debounce); rise/fall are combinational from stb/prev.
module gpio_in_bit
    import gpio_pkg::*;
#(
    parameter int DB_CYCLES = GPIO_DB_CYCLES
) (
    input  logic CLK,
    input  logic RST,
    input  logic pin_i,
    input  logic dir_i,
    output logic stb_o,
    output logic rise_o,
    output logic fall_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;
    logic dir_q;
    logic stb;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            dir_q   <= 1'b0;
        end else begin
            sync1_q <= pin_i;
            sync2_q <= sync1_q;
            prev_q  <= stb;
            dir_q   <= dir_i;
        end
    end

`ifdef GPIO_DEBOUNCE_EN
    localparam int            CW       = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          stb_q;
    logic          stb_d;

    // Any cycle where sync2 agrees with stb restarts the stability count.
    always_comb begin
        cnt_d = '0;
        stb_d = stb_q;
        if (sync2_q != stb_q) begin
            if (cnt_q == CNT_LAST) begin
                stb_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt_q <= '0;
            stb_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            stb_q <= stb_d;
        end
    end

    assign stb = stb_q;
`else
    assign stb = sync2_q;

    // DB_CYCLES has no effect without debounce; an out-of-range value only elaborates this empty block.
    if (DB_CYCLES < 1) begin : g_db_cycles_out_of_range
    end
`endif

    // Edges only count when the bit was an input both now and last cycle.
    assign stb_o  = stb;
    assign rise_o = stb & ~prev_q & is_input(dir_i) & is_input(dir_q);
    assign fall_o = ~stb & prev_q & is_input(dir_i) & is_input(dir_q);

endmodule

// File: rtl/gpio_port_io.sv
// Pad-side parallel port: output drive, synchronized inputs, read register, edge interrupt flags.
// Output path combinational; RD_DATA 1 cycle after RD_EN; IFLAG 2 edges after pad (+DB_CYCLES with GPIO_DEBOUNCE_EN); no backpressure.
module gpio_port_io
    import gpio_pkg::*;
#(
    parameter int WIDTH     = GPIO_WIDTH,
    parameter int DB_CYCLES = GPIO_DB_CYCLES
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] DIR,
    input  logic [WIDTH-1:0] DOUT_REG,
    input  logic [WIDTH-1:0] PIN_IN,
    output logic [WIDTH-1:0] PIN_OUT,
    output logic [WIDTH-1:0] PIN_OE,
    input  logic             RD_EN,
    output logic [WIDTH-1:0] RD_DATA,
    input  logic [WIDTH-1:0] IE_RISE,
    input  logic [WIDTH-1:0] IE_FALL,
    input  logic             CLR_EN,
    input  logic [WIDTH-1:0] CLR_MASK,
    output logic [WIDTH-1:0] IFLAG,
    output logic             IRQ
);

    logic [WIDTH-1:0] stb;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] iflag_q;
    logic [WIDTH-1:0] iflag_d;
    logic [WIDTH-1:0] rd_data_q;
    logic [WIDTH-1:0] rd_data_d;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        gpio_in_bit #(
            .DB_CYCLES(DB_CYCLES)
        ) u_in_bit (
            .CLK    (CLK),
            .RST    (RST),
            .pin_i  (PIN_IN[i]),
            .dir_i  (DIR[i]),
            .stb_o  (stb[i]),
            .rise_o (rise[i]),
            .fall_o (fall[i])
        );

        // Bits configured as inputs present 0 on the pad.
        assign PIN_OUT[i] = (DIR[i] == DIR_OUT) & DOUT_REG[i];
    end

    assign PIN_OE = DIR;

    // A new edge in the same cycle as a clear keeps the flag set.
    always_comb begin
        iflag_d = (iflag_q & ~({WIDTH{CLR_EN}} & CLR_MASK))
                | (rise & IE_RISE)
                | (fall & IE_FALL);
    end

    // Output bits read back the latch, not the pad.
    always_comb begin
        rd_data_d = rd_data_q;
        if (RD_EN) begin
            rd_data_d = (DOUT_REG & DIR) | (stb & ~DIR);
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            iflag_q   <= '0;
            rd_data_q <= '0;
        end else begin
            iflag_q   <= iflag_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign IFLAG   = iflag_q;
    assign IRQ     = |iflag_q;
    assign RD_DATA = rd_data_q;

endmodule

// File: tb/tb_gpio_port_io.sv
// Directed and randomized checks of gpio_port_io against a pad-history reference model.
module tb_gpio_port_io;

    localparam int W  = 8;
    localparam int DB = 4;
`ifdef GPIO_DEBOUNCE_EN
    localparam int DBL = DB;
`else
    localparam int DBL = 0;
`endif

    logic         CLK = 1'b0;
    logic         RST;
    logic [W-1:0] DIR, DOUT_REG, PIN_IN, IE_RISE, IE_FALL, CLR_MASK;
    logic         RD_EN, CLR_EN;
    logic [W-1:0] PIN_OUT, PIN_OE, RD_DATA, IFLAG;
    logic         IRQ;

    int checks = 0;
    int errors = 0;

    gpio_port_io #(
        .WIDTH     (W),
        .DB_CYCLES (DB)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .DIR      (DIR),
        .DOUT_REG (DOUT_REG),
        .PIN_IN   (PIN_IN),
        .PIN_OUT  (PIN_OUT),
        .PIN_OE   (PIN_OE),
        .RD_EN    (RD_EN),
        .RD_DATA  (RD_DATA),
        .IE_RISE  (IE_RISE),
        .IE_FALL  (IE_FALL),
        .CLR_EN   (CLR_EN),
        .CLR_MASK (CLR_MASK),
        .IFLAG    (IFLAG),
        .IRQ      (IRQ)
    );

    always #5 CLK = ~CLK;

    // Reference model: stable level derived from the history of sampled pad values.
    logic [W-1:0] pin_q[$];
    logic [W-1:0] m_stb, m_prev, m_dir, m_flag, m_rd;

    function automatic logic [W-1:0] next_stb();
        logic [W-1:0] r;
        logic         all_diff;
        logic         s;
`ifdef GPIO_DEBOUNCE_EN
        r = m_stb;
        for (int b = 0; b < W; b++) begin
            all_diff = 1'b1;
            for (int j = 2; j <= DB + 1; j++) begin
                s = (j < pin_q.size()) ? pin_q[j][b] : 1'b0;
                if (s == m_stb[b]) all_diff = 1'b0;
            end
            if (all_diff) r[b] = ~m_stb[b];
        end
`else
        all_diff = 1'b0;
        s        = 1'b0;
        r = (pin_q.size() > 1) ? pin_q[1] : '0;
`endif
        return r;
    endfunction

    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            pin_q.delete();
            m_stb  <= '0;
            m_prev <= '0;
            m_dir  <= '0;
            m_flag <= '0;
            m_rd   <= '0;
        end else begin
            pin_q.push_front(PIN_IN);
            if (pin_q.size() > DB + 3) void'(pin_q.pop_back());
            m_flag <= (m_flag & ~({W{CLR_EN}} & CLR_MASK))
                    | (m_stb & ~m_prev & ~DIR & ~m_dir & IE_RISE)
                    | (~m_stb & m_prev & ~DIR & ~m_dir & IE_FALL);
            if (RD_EN) m_rd <= (DOUT_REG & DIR) | (m_stb & ~DIR);
            m_prev <= m_stb;
            m_dir  <= DIR;
            m_stb  <= next_stb();
        end
    end

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge CLK);
    endtask

    initial begin
        RST = 1'b0; DIR = '0; DOUT_REG = '0; PIN_IN = '1; RD_EN = 1'b0;
        IE_RISE = '0; IE_FALL = '0; CLR_EN = 1'b0; CLR_MASK = '0;

        cycles(3);
        chk("rst_iflag", IFLAG, '0);
        chk("rst_rd", RD_DATA, '0);
        chk("rst_irq", W'(IRQ), '0);
        chk("rst_oe", PIN_OE, '0);

        RST = 1'b1;
        cycles(6 + DBL);
        chk("rel_iflag", IFLAG, '0);
        chk("rel_irq", W'(IRQ), '0);

        // Read path
        DIR = 8'h0F; DOUT_REG = 8'hA5; PIN_IN = 8'h3C;
        cycles(4 + DBL);
        RD_EN = 1'b1;
        cycles(1);
        RD_EN = 1'b0;
        chk("rd_data", RD_DATA, 8'h35);
        chk("pin_oe", PIN_OE, 8'h0F);
        chk("pin_out", PIN_OUT, 8'h05);
        PIN_IN = 8'h00;
        cycles(4 + DBL);
        chk("rd_hold", RD_DATA, 8'h35);

        // Rising edge on bit 0
        DIR = '0; DOUT_REG = '0; IE_RISE = 8'h01;
        cycles(2);
        chk("rise_pre", IFLAG, '0);
        PIN_IN = 8'h01;
        cycles(2 + DBL);
        chk("rise_early", IFLAG, '0);
        cycles(1);
        chk("rise_flag", IFLAG, 8'h01);
        chk("rise_irq", W'(IRQ), 8'h01);

        // Clear colliding with a new fall, then clear alone
        IE_FALL = 8'h01;
        PIN_IN = 8'h00;
        cycles(2 + DBL);
        CLR_EN = 1'b1; CLR_MASK = 8'h01;
        cycles(1);
        chk("clr_collide", IFLAG, 8'h01);
        cycles(1);
        CLR_EN = 1'b0;
        chk("clr_alone", IFLAG, '0);
        chk("clr_irq", W'(IRQ), '0);

        // Direction change on bit 2 must not create an edge
        IE_RISE = '0; IE_FALL = 8'hFF;
        DIR = 8'h04; DOUT_REG = 8'h04;
        cycles(4 + DBL);
        chk("dir_pin_out", PIN_OUT, 8'h04);
        DIR = 8'h00;
        cycles(4 + DBL);
        chk("dir_no_flag", IFLAG, '0);
        PIN_IN = 8'h04;
        cycles(4 + DBL);
        chk("dir_rise_off", IFLAG, '0);
        PIN_IN = 8'h00;
        cycles(3 + DBL);
        chk("dir_real_fall", IFLAG, 8'h04);
        CLR_EN = 1'b1; CLR_MASK = 8'hFF;
        cycles(1);
        CLR_EN = 1'b0;
        chk("dir_cleared", IFLAG, '0);

`ifdef GPIO_DEBOUNCE_EN
        IE_FALL = '0; IE_RISE = 8'h02;
        PIN_IN = 8'h02;
        cycles(DB - 1);
        PIN_IN = 8'h00;
        cycles(10);
        chk("db_glitch", IFLAG, '0);
        PIN_IN = 8'h02;
        cycles(DB);
        PIN_IN = 8'h00;
        cycles(10);
        chk("db_pulse", IFLAG, 8'h02);
        CLR_EN = 1'b1; CLR_MASK = 8'hFF;
        cycles(1);
        CLR_EN = 1'b0;
`endif

        // Randomized traffic against the model, with one mid-run reset
        for (int c = 0; c < 400; c++) begin
            @(negedge CLK);
            chk("rnd_iflag", IFLAG, m_flag);
            chk("rnd_irq", W'(IRQ), W'(|m_flag));
            chk("rnd_rd", RD_DATA, m_rd);
            chk("rnd_oe", PIN_OE, DIR);
            chk("rnd_out", PIN_OUT, DOUT_REG & DIR);
            if (c == 200) begin
                RST = 1'b0;
                #1;
                chk("mid_rst_iflag", IFLAG, '0);
                chk("mid_rst_rd", RD_DATA, '0);
                #1;
                RST = 1'b1;
            end
            if ($urandom_range(0, 7) == 0) DIR = W'($urandom);
            if ($urandom_range(0, 7) == 0) IE_RISE = W'($urandom);
            if ($urandom_range(0, 7) == 0) IE_FALL = W'($urandom);
            DOUT_REG = W'($urandom);
            PIN_IN   = PIN_IN ^ (W'($urandom) & W'($urandom) & W'($urandom));
            RD_EN    = 1'($urandom_range(0, 1));
            CLR_EN   = ($urandom_range(0, 5) == 0);
            CLR_MASK = W'($urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gpio_port_io.md
# gpio_port_io

Pad-side half of the processor's parallel I/O port. It consumes the per-bit direction register and the output data latch, and drives the pad enables and output values. It synchronizes and optionally debounces pad inputs, and returns port read data to the CPU. It also detects rising and falling edges on input bits and raises a level interrupt that the CPU clears by bit mask.

## Interface
- WIDTH, 8, number of port bits
- DB_CYCLES, 4, consecutive stable cycles needed to accept a new input level (used only with debounce compiled in); legal range is 1 or more

- CLK  in  1  system clock; all state updates on posedge
- RST  in  1  asynchronous, active-low reset
- DIR  in  WIDTH  per-bit direction from the direction register; 1 = output, 0 = input
- DOUT_REG  in  WIDTH  output data latch value
- PIN_IN  in  WIDTH  raw pad inputs, asynchronous to CLK
- PIN_OUT  out  WIDTH  pad output values
- PIN_OE  out  WIDTH  pad output enables
- RD_EN  in  1  CPU port-read strobe
- RD_DATA  out  WIDTH  registered port read data
- IE_RISE  in  WIDTH  per-bit rising-edge interrupt enable
- IE_FALL  in  WIDTH  per-bit falling-edge interrupt enable
- CLR_EN  in  1  interrupt-flag clear strobe
- CLR_MASK  in  WIDTH  bits to clear when CLR_EN=1
- IFLAG  out  WIDTH  per-bit pending interrupt flags
- IRQ  out  1  OR-reduction of IFLAG

## Operation
- Output path (combinational):
  - PIN_OE = DIR.
  - PIN_OUT = DOUT_REG & DIR, so undriven bits present 0.
- Input path:
  - Each bit passes through a two-flop synchronizer (sync1 → sync2).
  - This produces the stable level `stb`.
  - Without debounce, `stb` = sync2.
- Edge detect:
  - Registers `prev` <= `stb` and `dir_q` <= DIR every cycle.
  - rise = `stb` & ~`prev` & ~DIR & ~`dir_q`.
  - fall = ~`stb` & `prev` & ~DIR & ~`dir_q`.
  - An edge is counted only on bits that were inputs in both this cycle and the previous one. A 1→0 change on DIR therefore never produces a spurious edge.
- Flags:
  - IFLAG[i] <= (IFLAG[i] & ~(CLR_EN & CLR_MASK[i])) | (rise[i] & IE_RISE[i]) | (fall[i] & IE_FALL[i]).
  - When set and clear happen in the same cycle, set wins.
  - Clearing a bit whose flag is 0 has no effect.
- IRQ = |IFLAG, combinational from the flag register.
- Read:
  - On a cycle with RD_EN=1, RD_DATA <= (DOUT_REG & DIR) | (`stb` & ~DIR).
  - RD_DATA holds its value when RD_EN=0.
  - Output bits read back the latch value, not the pad.
- Reset (RST=0) clears everything:
  - sync1, sync2, `stb`, `prev`, `dir_q`, debounce counters, IFLAG and RD_DATA all go to 0.
  - IRQ is 0.
  - PIN_OE and PIN_OUT follow DIR and DOUT_REG. Those come from upstream registers, which are themselves 0 in reset.
  - Reset asserted mid-operation discards pending flags and debounce progress immediately.

## Timing
- PIN_IN change set up before edge k:
  - sync1 updates at k.
  - `stb` updates at k+1.
  - IFLAG is set at k+2 (no debounce).
- RD_DATA reflects `stb` at the RD_EN edge, with 1-cycle latency.
- A pad pulse shorter than one CLK period may be missed; this is acceptable.
- With debounce:
  - `stb` updates at k+1+DB_CYCLES.
  - IFLAG is set at k+2+DB_CYCLES.
- CLR_EN takes effect at the next edge. IRQ falls in the same cycle IFLAG clears.

## Configuration
- Macro GPIO_DEBOUNCE_EN.
- Defined:
  - Each bit has a counter of width $clog2(DB_CYCLES+1).
  - When sync2 ≠ `stb`, the counter increments. When sync2 = `stb`, it resets to 0.
  - When the counter equals DB_CYCLES-1 and a mismatch is present, `stb` <= sync2 and the counter goes to 0.
  - Glitches shorter than DB_CYCLES cycles never reach `stb`.
- Undefined: no counters, `stb` = sync2, and DB_CYCLES is ignored.

## Structure
- Shared package gpio_pkg holds:
  - the WIDTH default;
  - the DB_CYCLES default;
  - the DIR encoding constants DIR_IN=1'b0 and DIR_OUT=1'b1.
- Sub-module gpio_in_bit, instantiated WIDTH times, contains the per-bit synchronizer, optional debounce counter and `prev` register. It outputs `stb`, rise and fall.
- The top level holds the flags, the read register and the output path.

## Test plan
- Reset behaviour: RST=0 with PIN_IN=8'hFF → IFLAG=0, RD_DATA=0, IRQ=0. Release RST with IE all 0 → no flags set.
- Read path: DIR=8'h0F, DOUT_REG=8'hA5, PIN_IN=8'h3C, RD_EN pulse after settle → RD_DATA=8'h35 one cycle later. Check PIN_OE=8'h0F and PIN_OUT=8'h05.
- Rising edge: DIR=0, IE_RISE=8'h01, PIN_IN[0] goes 0→1 before edge k → IFLAG=8'h01 and IRQ=1 at k+2 (k+6 with debounce and DB_CYCLES=4).
- Clear collision: CLR_EN=1 and CLR_MASK=8'h01 in the same cycle as a new enabled fall on bit 0 → IFLAG[0] stays 1. Repeat the clear alone → IFLAG=0 and IRQ=0.
- Direction change: bit 2 with DOUT_REG=1 and PIN_IN=0, DIR toggled 1→0, IE_FALL=8'hFF → no flag set. A subsequent real PIN_IN 1→0 on bit 2 does set the flag.
- Debounce (macro on, DB_CYCLES=4):
  - 3-cycle high glitch → `stb` unchanged, no flag.
  - 4-cycle high pulse → `stb` rises, and IFLAG sets when IE_RISE is enabled.
